// File: rtl/soc_bram_wb.sv
// Wishbone-classic slave front-end for a 32-bit single-port BRAM; optional post-reset zero-fill via SOC_BRAM_WB_CLEAR_EN.
// Latency: request to wb_ack = 2 edges, one access per 3 cycles; requests wait (no ack) until clear_done.
module soc_bram_wb #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] wb_addr,
    input  logic [31:0]   wb_wdata,
    input  logic [3:0]    wb_wmsk,
    input  logic          wb_we,
    input  logic          wb_cyc,
    output logic [31:0]   wb_rdata,
    output logic          wb_ack,
    output logic [AW-1:0] bram_addr,
    output logic [31:0]   bram_wdata,
    output logic [3:0]    bram_wmsk,
    output logic          bram_we,
    input  logic [31:0]   bram_rdata,
    output logic          clear_done
);

`ifdef SOC_BRAM_WB_CLEAR_EN
    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_ACC, S_ACK} state_t;
    localparam state_t RST_STATE = S_CLEAR;
    logic [AW-1:0] clr_cnt;
`else
    typedef enum logic [1:0] {S_IDLE, S_ACC, S_ACK} state_t;
    localparam state_t RST_STATE = S_IDLE;
    assign clear_done = 1'b1;
`endif

    state_t state;

    // BRAM output is registered at the access edge, so it is valid exactly in the ack cycle.
    assign wb_rdata = wb_ack ? bram_rdata : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RST_STATE;
            wb_ack     <= 1'b0;
            bram_we    <= 1'b0;
            bram_addr  <= '0;
            bram_wdata <= 32'h0;
            bram_wmsk  <= 4'hF;
`ifdef SOC_BRAM_WB_CLEAR_EN
            clr_cnt    <= '0;
            clear_done <= 1'b0;
`endif
        end else begin
            case (state)
`ifdef SOC_BRAM_WB_CLEAR_EN
                S_CLEAR: begin
                    bram_we    <= 1'b1;
                    bram_wmsk  <= 4'h0;
                    bram_wdata <= 32'h0;
                    bram_addr  <= clr_cnt;
                    clr_cnt    <= clr_cnt + AW'(1);
                    // The last zero-write is still on the port during the first IDLE
                    // cycle and lands at the next edge, before any bus access can.
                    if (clr_cnt == '1) begin
                        clear_done <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
`endif
                S_IDLE: begin
                    if (wb_cyc) begin
                        bram_addr  <= wb_addr;
                        bram_wdata <= wb_wdata;
                        bram_wmsk  <= wb_wmsk;
                        bram_we    <= wb_we;
                        state      <= S_ACC;
                    end else begin
                        bram_we <= 1'b0;
                    end
                end
                S_ACC: begin
                    bram_we <= 1'b0;
                    if (wb_cyc) begin
                        wb_ack <= 1'b1;
                        state  <= S_ACK;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
                S_ACK: begin
                    wb_ack <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    wb_ack  <= 1'b0;
                    bram_we <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_bram_wb.sv
// Directed bench for soc_bram_wb with a behavioural BRAM (1-cycle read, active-low byte mask).
module tb_soc_bram_wb;
    localparam int AW = 4;
`ifdef SOC_BRAM_WB_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] wb_addr = '0;
    logic [31:0]   wb_wdata = '0;
    logic [3:0]    wb_wmsk = 4'hF;
    logic          wb_we = 1'b0;
    logic          wb_cyc = 1'b0;
    logic [31:0]   wb_rdata;
    logic          wb_ack;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_wdata;
    logic [3:0]    bram_wmsk;
    logic          bram_we;
    logic [31:0]   bram_rdata;
    logic          clear_done;

    int checks = 0;
    int errors = 0;
    logic do_preload = 1'b1;
    logic [31:0] mem [0:(1<<AW)-1];

    soc_bram_wb #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_wmsk(wb_wmsk),
        .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_rdata(wb_rdata), .wb_ack(wb_ack),
        .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_wmsk(bram_wmsk),
        .bram_we(bram_we), .bram_rdata(bram_rdata), .clear_done(clear_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (do_preload) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'hA5A50000 | i;
        end else if (bram_we) begin
            for (int b = 0; b < 4; b++)
                if (!bram_wmsk[b]) mem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
        end
        bram_rdata <= mem[bram_addr];
    end

    function automatic logic [31:0] init_val(input int i);
        return CLR ? 32'h0 : (32'hA5A50000 | i);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_clear();
        int n = 0;
        while (!clear_done && n < 60) begin
            tick();
            n++;
        end
        chk("clear_done_after_reset", 32'(clear_done), 32'd1);
    endtask

    task automatic access(input string name, input logic we, input logic [AW-1:0] addr,
                          input logic [31:0] wd, input logic [3:0] msk,
                          input logic [31:0] exp, input int exp_lat);
        int n = 0;
        bit got = 0;
        wb_we = we; wb_addr = addr; wb_wdata = wd; wb_wmsk = msk; wb_cyc = 1'b1;
        while (!got && n < 60) begin
            tick();
            n++;
            if (wb_ack) got = 1;
            else chk({name, "_rdata_gated"}, wb_rdata, 32'h0);
        end
        if (got && !we) chk({name, "_rdata"}, wb_rdata, exp);
        wb_cyc = 1'b0;
        chk({name, "_latency"}, 32'(n), 32'(exp_lat));
        tick();
        chk({name, "_ack_one_cycle"}, 32'(wb_ack), 32'd0);
        chk({name, "_rdata_after_ack"}, wb_rdata, 32'h0);
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wd;
        logic [3:0]    msk;
        logic [31:0]   exp;
    } vec_t;
    vec_t vecs [14];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n, done_at, ack_at, k;

        vecs[0]  = '{1'b1, 4'd5,  32'hDEADBEEF, 4'h0, 32'h0};
        vecs[1]  = '{1'b0, 4'd5,  32'h0,        4'hF, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 4'd7,  32'h11223344, 4'h0, 32'h0};
        vecs[3]  = '{1'b1, 4'd7,  32'hAABBCCDD, 4'b1010, 32'h0};
        vecs[4]  = '{1'b0, 4'd7,  32'h0,        4'hF, 32'h11BB33DD};
        vecs[5]  = '{1'b1, 4'd3,  32'hFFFFFFFF, 4'hF, 32'h0};
        vecs[6]  = '{1'b0, 4'd3,  32'h0,        4'hF, init_val(3)};
        vecs[7]  = '{1'b1, 4'd0,  32'hC0DE0000, 4'h0, 32'h0};
        vecs[8]  = '{1'b1, 4'd1,  32'hC0DE0001, 4'h0, 32'h0};
        vecs[9]  = '{1'b1, 4'd2,  32'hC0DE0002, 4'h0, 32'h0};
        vecs[10] = '{1'b1, 4'd3,  32'hC0DE0003, 4'h0, 32'h0};
        vecs[11] = '{1'b0, 4'd15, 32'h0,        4'hF, init_val(15)};
        vecs[12] = '{1'b1, 4'd15, 32'hFEEDFACE, 4'h0, 32'h0};
        vecs[13] = '{1'b0, 4'd15, 32'h0,        4'hF, 32'hFEEDFACE};

        // Reset with preload, then check reset outputs.
        repeat (3) @(posedge clk);
        do_preload = 1'b0;
        #1;
        chk("rst_wb_ack", 32'(wb_ack), 32'd0);
        chk("rst_wb_rdata", wb_rdata, 32'h0);
        chk("rst_bram_we", 32'(bram_we), 32'd0);
        chk("rst_bram_addr", 32'(bram_addr), 32'd0);
        chk("rst_bram_wdata", bram_wdata, 32'h0);
        chk("rst_bram_wmsk", 32'(bram_wmsk), 32'hF);
        chk("rst_clear_done", 32'(clear_done), CLR ? 32'd0 : 32'd1);

        // Read of addr 9 presented right after reset release.
        rst_n = 1'b1;
        wb_cyc = 1'b1; wb_we = 1'b0; wb_addr = 4'd9;
        n = 0; done_at = clear_done ? 0 : -1; ack_at = -1;
        while (ack_at < 0 && n < 60) begin
            tick();
            n++;
            if (clear_done && done_at < 0) done_at = n;
            if (wb_ack) begin
                ack_at = n;
                chk("post_reset_read_rdata", wb_rdata, init_val(9));
            end
        end
        wb_cyc = 1'b0;
        chk("clear_done_edge", 32'(done_at), CLR ? 32'd16 : 32'd0);
        chk("post_reset_read_latency", 32'(ack_at), CLR ? 32'd18 : 32'd2);
        tick();

        for (int i = 0; i < 14; i++)
            access($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wd,
                   vecs[i].msk, vecs[i].exp, 2);

        // Back-to-back reads with wb_cyc held high.
        wb_cyc = 1'b1; wb_we = 1'b0; wb_addr = 4'd0; k = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (wb_ack) begin
                chk($sformatf("b2b_ack%0d_cycle", k), 32'(c), 32'(3 * k + 2));
                chk($sformatf("b2b_ack%0d_data", k), wb_rdata, 32'hC0DE0000 | k);
                k++;
                if (k < 4) wb_addr = AW'(k);
                else wb_cyc = 1'b0;
            end else begin
                chk($sformatf("b2b_gated_c%0d", c), wb_rdata, 32'h0);
            end
        end
        chk("b2b_ack_count", 32'(k), 32'd4);

        // Write aborted in the ACC cycle still commits, without an ack.
        wb_cyc = 1'b1; wb_we = 1'b1; wb_addr = 4'd9; wb_wdata = 32'h0BADF00D; wb_wmsk = 4'h0;
        tick();
        wb_cyc = 1'b0;
        tick();
        chk("abort_no_ack_e1", 32'(wb_ack), 32'd0);
        tick();
        chk("abort_no_ack_e2", 32'(wb_ack), 32'd0);
        access("abort_readback", 1'b0, 4'd9, 32'h0, 4'hF, 32'h0BADF00D, 2);

        // Reset during a write's ACC cycle: bram_we drops at once, write lost.
        wb_cyc = 1'b1; wb_we = 1'b1; wb_addr = 4'd12; wb_wdata = 32'h12345678; wb_wmsk = 4'h0;
        tick();
        chk("rst_acc_we_before", 32'(bram_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_acc_we_dropped", 32'(bram_we), 32'd0);
        wb_cyc = 1'b0;
        tick();
        rst_n = 1'b1;
        if (CLR) wait_clear();

        // Reset during the ACK cycle.
        wb_cyc = 1'b1; wb_we = 1'b0; wb_addr = 4'd5;
        tick();
        tick();
        chk("rst_ack_before", 32'(wb_ack), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_ack_dropped", 32'(wb_ack), 32'd0);
        chk("rst_ack_rdata", wb_rdata, 32'h0);
        chk("rst_ack_we", 32'(bram_we), 32'd0);
        wb_cyc = 1'b0;
        tick();
        rst_n = 1'b1;
        if (CLR) wait_clear();
        access("idle_after_reset", 1'b0, 4'd12, 32'h0, 4'hF, init_val(12), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
